// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- generic inter-stage pipeline register (D/E, E/M, M/W).
//
// Carries instr, pc, NSLOT opaque data slots, destination register (a3) and
// Tnew from one stage to the next, with stall-hold, flush-to-bubble, a valid
// bit and a combinational forwarding-ready flag.
//
// Per-edge priority: reset > flush > hold (en=0) > load (en=1).
//
// Parameters:
//   DATA_W    width of one data slot
//   NSLOT     number of data slots carried
//   TNEW_W    width of the Tnew field
//   DEC_TNEW  1 = Tnew decremented (saturating at 0) on load, 0 = passed through
//   RESET_PC  pc value loaded on reset
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              1 = load new contents, 0 = hold (stall)
//   flush           1 = insert a bubble on this edge (pc still taken from in_pc)
//   in_valid        upstream slot holds a real instruction
//   in_instr/in_pc  upstream instruction word / pc
//   in_data         packed data slots, slot k = [k*DATA_W +: DATA_W]
//   in_a3, in_tnew  upstream destination register / Tnew
//   out_*           registered copies of the above
//   out_fwd_rdy     out_valid && out_a3 != 0 && out_tnew == 0 (from registers only)
//
// Optional feature, macro PIPE_EXC_EN:
//   adds in_exc/in_bd inputs and out_exc/out_bd outputs. A non-zero out_exc
//   masks out_a3 to 0 and forces out_fwd_rdy low, so a faulting instruction
//   never forwards. out_bd is kept on flush (taken from in_bd), cleared on reset.

module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NSLOT    = 2,
    parameter int unsigned TNEW_W   = 4,
    parameter bit          DEC_TNEW = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [31:0]             in_instr,
    input  logic [31:0]             in_pc,
    input  logic [NSLOT*DATA_W-1:0] in_data,
    input  logic [4:0]              in_a3,
    input  logic [TNEW_W-1:0]       in_tnew,
`ifdef PIPE_EXC_EN
    input  logic [4:0]              in_exc,
    input  logic                    in_bd,
    output logic [4:0]              out_exc,
    output logic                    out_bd,
`endif
    output logic                    out_valid,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc,
    output logic [NSLOT*DATA_W-1:0] out_data,
    output logic [4:0]              out_a3,
    output logic [TNEW_W-1:0]       out_tnew,
    output logic                    out_fwd_rdy
);

    logic                    valid_q;
    logic [31:0]             instr_q;
    logic [31:0]             pc_q;
    logic [NSLOT*DATA_W-1:0] data_q;
    logic [4:0]              a3_q;
    logic [TNEW_W-1:0]       tnew_q;
    logic [TNEW_W-1:0]       tnew_next;

    // Saturating decrement: a Tnew of 0 stays 0 instead of wrapping.
    always_comb begin
        tnew_next = in_tnew;
        if (DEC_TNEW && (in_tnew != '0)) begin
            tnew_next = in_tnew - TNEW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= RESET_PC;
            data_q  <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
        end else if (flush) begin
            // Bubble keeps the incoming pc so EPC logic downstream still has it.
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= in_pc;
            data_q  <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
        end else if (en) begin
            // An invalid slot still carries instr/pc/data but never claims a
            // destination register or a pending Tnew.
            valid_q <= in_valid;
            instr_q <= in_instr;
            pc_q    <= in_pc;
            data_q  <= in_data;
            a3_q    <= in_valid ? in_a3 : '0;
            tnew_q  <= in_valid ? tnew_next : '0;
        end
    end

`ifdef PIPE_EXC_EN
    logic [4:0] exc_q;
    logic       bd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_q <= '0;
            bd_q  <= 1'b0;
        end else if (flush) begin
            exc_q <= '0;
            bd_q  <= in_bd;
        end else if (en) begin
            exc_q <= in_exc;
            bd_q  <= in_bd;
        end
    end

    assign out_exc     = exc_q;
    assign out_bd      = bd_q;
    assign out_a3      = (exc_q != '0) ? '0 : a3_q;
    assign out_fwd_rdy = valid_q && (exc_q == '0) && (a3_q != '0) && (tnew_q == '0);
`else
    assign out_a3      = a3_q;
    assign out_fwd_rdy = valid_q && (a3_q != '0) && (tnew_q == '0);
`endif

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;
    assign out_data  = data_q;
    assign out_tnew  = tnew_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: two instances (DEC_TNEW=1 and DEC_TNEW=0)
// share all inputs and are compared every cycle against a behavioural model,
// plus directed literal checks for the reset/load/saturation/hold/flush cases.
// Honours PIPE_EXC_EN when the RTL is built with it.

module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NSLOT  = 2;
    localparam int unsigned TNEW_W = 4;
    localparam int unsigned DW     = NSLOT * DATA_W;

    logic              clk = 1'b0;
    logic              reset, en, flush, in_valid;
    logic [31:0]       in_instr, in_pc;
    logic [DW-1:0]     in_data;
    logic [4:0]        in_a3;
    logic [TNEW_W-1:0] in_tnew;
    logic [4:0]        in_exc;
    logic              in_bd;

    logic              v1, v0, f1, f0;
    logic [31:0]       i1, i0, p1, p0;
    logic [DW-1:0]     d1, d0;
    logic [4:0]        a1, a0;
    logic [TNEW_W-1:0] t1, t0;
    logic [4:0]        e1, e0;
    logic              b1, b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .NSLOT(NSLOT), .TNEW_W(TNEW_W),
        .DEC_TNEW(1'b1), .RESET_PC(32'h0000_3000)
    ) dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_data(in_data), .in_a3(in_a3), .in_tnew(in_tnew),
`ifdef PIPE_EXC_EN
        .in_exc(in_exc), .in_bd(in_bd), .out_exc(e1), .out_bd(b1),
`endif
        .out_valid(v1), .out_instr(i1), .out_pc(p1), .out_data(d1),
        .out_a3(a1), .out_tnew(t1), .out_fwd_rdy(f1)
    );

    pipe_stage_reg #(
        .DATA_W(DATA_W), .NSLOT(NSLOT), .TNEW_W(TNEW_W),
        .DEC_TNEW(1'b0), .RESET_PC(32'h0000_3000)
    ) dut0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_data(in_data), .in_a3(in_a3), .in_tnew(in_tnew),
`ifdef PIPE_EXC_EN
        .in_exc(in_exc), .in_bd(in_bd), .out_exc(e0), .out_bd(b0),
`endif
        .out_valid(v0), .out_instr(i0), .out_pc(p0), .out_data(d0),
        .out_a3(a0), .out_tnew(t0), .out_fwd_rdy(f0)
    );

`ifndef PIPE_EXC_EN
    assign e1 = '0;
    assign e0 = '0;
    assign b1 = 1'b0;
    assign b0 = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_known = 0;
    bit          m_valid;
    logic [31:0] m_instr, m_pc;
    logic [DW-1:0] m_data;
    int          m_a3, m_tnew_dec, m_tnew_raw, m_exc;
    bit          m_bd;

    always @(posedge clk) begin
        if (reset) begin
            m_known = 1; m_valid = 0; m_instr = 0; m_pc = 32'h3000; m_data = 0;
            m_a3 = 0; m_tnew_dec = 0; m_tnew_raw = 0; m_exc = 0; m_bd = 0;
        end else if (flush) begin
            m_valid = 0; m_instr = 0; m_pc = in_pc; m_data = 0;
            m_a3 = 0; m_tnew_dec = 0; m_tnew_raw = 0; m_exc = 0; m_bd = in_bd;
        end else if (en) begin
            m_valid = in_valid; m_instr = in_instr; m_pc = in_pc; m_data = in_data;
            m_a3       = in_valid ? int'(in_a3) : 0;
            m_tnew_raw = in_valid ? int'(in_tnew) : 0;
            m_tnew_dec = (m_tnew_raw > 0) ? m_tnew_raw - 1 : 0;
            m_exc = int'(in_exc); m_bd = in_bd;
        end
    end

    function automatic int exp_a3();
`ifdef PIPE_EXC_EN
        if (m_exc != 0) return 0;
`endif
        return m_a3;
    endfunction

    function automatic bit exp_fwd(input int tnew);
        return m_valid && exp_a3() != 0 && tnew == 0;
    endfunction

    always @(negedge clk) begin
        if (m_known) begin
            check("valid1", 64'(v1), 64'(m_valid));
            check("valid0", 64'(v0), 64'(m_valid));
            check("instr1", 64'(i1), 64'(m_instr));
            check("instr0", 64'(i0), 64'(m_instr));
            check("pc1",    64'(p1), 64'(m_pc));
            check("pc0",    64'(p0), 64'(m_pc));
            check("data1",  d1, m_data);
            check("data0",  d0, m_data);
            check("a3_1",   64'(a1), 64'(exp_a3()));
            check("a3_0",   64'(a0), 64'(exp_a3()));
            check("tnew1",  64'(t1), 64'(m_tnew_dec));
            check("tnew0",  64'(t0), 64'(m_tnew_raw));
            check("fwd1",   64'(f1), 64'(exp_fwd(m_tnew_dec)));
            check("fwd0",   64'(f0), 64'(exp_fwd(m_tnew_raw)));
`ifdef PIPE_EXC_EN
            check("exc1", 64'(e1), 64'(m_exc));
            check("exc0", 64'(e0), 64'(m_exc));
            check("bd1",  64'(b1), 64'(m_bd));
            check("bd0",  64'(b0), 64'(m_bd));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_instr = $urandom;
        in_pc    = $urandom & 32'hFFFF_FFFC;
        in_data  = {$urandom, $urandom};
        in_a3    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        in_tnew  = TNEW_W'($urandom_range(0, 15));
        in_exc   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
        in_bd    = 1'($urandom);
    endtask

    initial begin
        reset = 1; en = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0;
        in_data = 0; in_a3 = 0; in_tnew = 0; in_exc = 0; in_bd = 0;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        check("rst_valid", 64'(v1), 64'd0);
        check("rst_pc",    64'(p1), 64'h3000);
        check("rst_instr", 64'(i1), 64'd0);
        check("rst_tnew",  64'(t1), 64'd0);
        check("rst_fwd",   64'(f1), 64'd0);

        // Load with Tnew decrement.
        en = 1; in_valid = 1; in_instr = 32'h0109_4021; in_pc = 32'h3004;
        in_a3 = 5'd8; in_tnew = 4'd2; in_data = 64'h1111_2222_3333_4444;
        tick();
        check("ld_tnew",  64'(t1), 64'd1);
        check("ld_a3",    64'(a1), 64'd8);
        check("ld_fwd",   64'(f1), 64'd0);
        check("ld_pc",    64'(p1), 64'h3004);
        in_tnew = 4'd1;
        tick();
        check("ld2_tnew", 64'(t1), 64'd0);
        check("ld2_fwd",  64'(f1), 64'd1);

        // Saturation at 0, and pass-through with DEC_TNEW=0.
        in_tnew = 4'd0;
        tick();
        check("sat_tnew", 64'(t1), 64'd0);
        in_tnew = 4'd3;
        tick();
        check("pass_tnew", 64'(t0), 64'd3);
        check("dec_tnew",  64'(t1), 64'd2);

        // Hold for 3 edges with changing inputs.
        in_pc = 32'h3010;
        tick();
        en = 0;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            in_exc = 0;
            tick();
            check("hold_pc",    64'(p1), 64'h3010);
            check("hold_tnew",  64'(t1), 64'd2);
            check("hold_instr", 64'(i1), 64'h0109_4021);
            check("hold_a3",    64'(a1), 64'd8);
        end

        // Flush while stalled.
        flush = 1; in_pc = 32'h3020;
        tick();
        check("fl_valid", 64'(v1), 64'd0);
        check("fl_instr", 64'(i1), 64'd0);
        check("fl_a3",    64'(a1), 64'd0);
        check("fl_tnew",  64'(t1), 64'd0);
        check("fl_pc",    64'(p1), 64'h3020);
        reset = 1;
        tick();
        check("flrst_pc", 64'(p1), 64'h3000);
        reset = 0; flush = 0;

`ifdef PIPE_EXC_EN
        en = 1; in_valid = 1; in_exc = 5'd4; in_a3 = 5'd9; in_tnew = 4'd0;
        tick();
        check("exc_exc", 64'(e1), 64'd4);
        check("exc_a3",  64'(a1), 64'd0);
        check("exc_fwd", 64'(f1), 64'd0);
        flush = 1;
        tick();
        check("exc_fl", 64'(e1), 64'd0);
        flush = 0;
`endif

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            reset = 1'($urandom_range(0, 31) == 0);
            flush = 1'($urandom_range(0, 7) == 0);
            en    = 1'($urandom_range(0, 3) != 0);
            tick();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
